// File: rtl/port_output_arbiter_if.sv
// Handshake bundle between N upstream FIFO outputs, the round-robin arbiter and one downstream sink.
// master = environment driving valids/data/ready-out, slave = the arbiter.
interface port_output_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_INPUTS = 4
);
    localparam int IDX_WIDTH = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS-1:0] i__data_in_valid;
    logic [DATA_WIDTH-1:0] i__data_in [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] o__data_in_ready;
    logic                  o__data_out_valid;
    logic [DATA_WIDTH-1:0] o__data_out;
    logic                  i__data_out_ready;
    logic [IDX_WIDTH-1:0]  o__grant_idx;
    logic                  i__clear_all;

    modport master (
        output i__data_in_valid,
        output i__data_in,
        input  o__data_in_ready,
        input  o__data_out_valid,
        input  o__data_out,
        output i__data_out_ready,
        input  o__grant_idx,
        output i__clear_all
    );

    modport slave (
        input  i__data_in_valid,
        input  i__data_in,
        output o__data_in_ready,
        output o__data_out_valid,
        output o__data_out,
        input  i__data_out_ready,
        output o__grant_idx,
        input  i__clear_all
    );
endinterface

// File: rtl/port_output_arbiter.sv
// Round-robin arbiter of NUM_INPUTS FIFO outputs into a one-entry output register.
// Latency 1 cycle input to output; downstream stall holds the register and drops all input readies.
module port_output_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_INPUTS = 4
) (
    input logic                  clk,
    input logic                  reset,
    port_output_arbiter_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(NUM_INPUTS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

    logic [IDX_WIDTH-1:0]  r__last_grant;
    logic [IDX_WIDTH-1:0]  r__grant_idx;
    logic                  r__out_valid;
    logic [DATA_WIDTH-1:0] r__out_data;

    logic [IDX_WIDTH-1:0]  cand_idx;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic                  sel_found;
    logic                  slot_free;
    logic                  in_xfer;
    logic [NUM_INPUTS-1:0] in_ready;

    // Search starts one past the last winner so every requester is reached within NUM_INPUTS grants.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int j = 1; j <= NUM_INPUTS; j++) begin
            cand_idx = IDX_WIDTH'((int'(r__last_grant) + j) % NUM_INPUTS);
            if (!sel_found && bus.i__data_in_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign slot_free = !r__out_valid || bus.i__data_out_ready;

    always_comb begin
        in_ready = '0;
        if (sel_found && slot_free && !bus.i__clear_all && !reset) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    assign in_xfer = |in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r__out_valid  <= 1'b0;
            r__grant_idx  <= '0;
            r__last_grant <= LAST_IDX;
        end else if (bus.i__clear_all) begin
            r__out_valid  <= 1'b0;
            r__last_grant <= LAST_IDX;
        end else if (slot_free) begin
            r__out_valid <= in_xfer;
            if (in_xfer) begin
                r__grant_idx  <= sel_idx;
                r__last_grant <= sel_idx;
            end
        end
    end

    // Data path is qualified by r__out_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            r__out_data <= bus.i__data_in[sel_idx];
        end
    end

    assign bus.o__data_in_ready  = in_ready;
    assign bus.o__data_out_valid = r__out_valid;
    assign bus.o__data_out       = r__out_data;
    assign bus.o__grant_idx      = r__grant_idx;
endmodule

// File: tb/tb_port_output_arbiter.sv
// Directed bench for port_output_arbiter with a per-cycle monitor and reference queue.
module tb_port_output_arbiter;
    localparam int DW = 64;
    localparam int NI = 4;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  i;
    } ent_t;
    ent_t sb[$];

    bit          prev_hold = 1'b0;
    logic [63:0] prev_data;
    logic [1:0]  prev_idx;

    port_output_arbiter_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus ();

    port_output_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] d, input logic [1:0] idx);
        check({tag, "_valid"}, 64'(bus.o__data_out_valid), 64'd1);
        check({tag, "_data"}, bus.o__data_out, d);
        check({tag, "_idx"}, 64'(bus.o__grant_idx), 64'(idx));
    endtask

    task automatic set_data_default();
        for (int k = 0; k < NI; k++) bus.i__data_in[k] = 64'hA0 + 64'(k);
    endtask

    // Per-cycle monitor: sampled mid-cycle, inputs only change just after posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_onehot0", 64'($onehot0(bus.o__data_in_ready)), 64'd1);
            if (prev_hold) begin
                check("hold_valid", 64'(bus.o__data_out_valid), 64'd1);
                check("hold_data", bus.o__data_out, prev_data);
                check("hold_idx", 64'(bus.o__grant_idx), 64'(prev_idx));
            end
            if (bus.o__data_out_valid && !bus.i__data_out_ready && !reset)
                check("bp_ready_zero", 64'(bus.o__data_in_ready), 64'd0);
            if (bus.o__data_out_valid && bus.i__data_out_ready && !reset && !bus.i__clear_all) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_word", 64'd1, 64'd0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    check("sb_data", bus.o__data_out, e.d);
                    check("sb_idx", 64'(bus.o__grant_idx), 64'(e.i));
                end
            end
            for (int k = 0; k < NI; k++) begin
                if (bus.i__data_in_valid[k] && bus.o__data_in_ready[k]) begin
                    ent_t e;
                    e.d = bus.i__data_in[k];
                    e.i = 2'(k);
                    sb.push_back(e);
                end
            end
            if (reset || bus.i__clear_all) sb.delete();
            prev_hold = bus.o__data_out_valid && !bus.i__data_out_ready && !reset && !bus.i__clear_all;
            prev_data = bus.o__data_out;
            prev_idx  = bus.o__grant_idx;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_d [5];
        logic [1:0]  exp_i [5];
        reset                 = 1'b1;
        bus.i__data_in_valid  = '0;
        bus.i__data_out_ready = 1'b0;
        bus.i__clear_all      = 1'b0;
        set_data_default();

        // Reset state, including readies held low with requests pending.
        tick();
        tick();
        check("rst_out_valid", 64'(bus.o__data_out_valid), 64'd0);
        check("rst_grant_idx", 64'(bus.o__grant_idx), 64'd0);
        bus.i__data_in_valid = 4'b1111;
        #1;
        check("rst_ready", 64'(bus.o__data_in_ready), 64'd0);
        mon_en = 1'b1;

        // Full round robin after reset: first grant to input 0.
        bus.i__data_out_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("first_ready", 64'(bus.o__data_in_ready), 64'd1);
        exp_d = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA0};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int s = 0; s < 5; s++) begin
            tick();
            check_out("rr", exp_d[s], exp_i[s]);
        end

        // Sparse requests 0101: alternate 2,0 and never ready on odd inputs.
        bus.i__data_in_valid = 4'b0101;
        exp_d = '{64'hA2, 64'hA0, 64'hA2, 64'hA0, 64'hA2};
        exp_i = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        for (int s = 0; s < 4; s++) begin
            #1;
            check("odd_ready", 64'(bus.o__data_in_ready & 4'b1010), 64'd0);
            tick();
            check_out("alt", exp_d[s], exp_i[s]);
        end

        // Backpressure: 0x55 held for 5 cycles, then accepted with next word behind it.
        bus.i__data_in[0]    = 64'h55;
        bus.i__data_in_valid = 4'b0001;
        tick();
        check_out("load55", 64'h55, 2'd0);
        bus.i__data_out_ready = 1'b0;
        bus.i__data_in_valid  = 4'b1111;
        set_data_default();
        for (int s = 0; s < 5; s++) begin
            #1;
            check("bp_ready", 64'(bus.o__data_in_ready), 64'd0);
            tick();
            check_out("bp_hold", 64'h55, 2'd0);
        end
        bus.i__data_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.o__data_in_ready), 64'b0010);
        tick();
        check_out("bp_next", 64'hA1, 2'd1);

        // Wrap from last grant 3 back to 0.
        bus.i__data_in_valid = 4'b1000;
        tick();
        check_out("to3", 64'hA3, 2'd3);
        bus.i__data_in_valid = 4'b1001;
        tick();
        check_out("wrap0", 64'hA0, 2'd0);
        tick();
        check_out("wrap3", 64'hA3, 2'd3);

        // Clear with a full, stalled register.
        bus.i__data_out_ready = 1'b0;
        bus.i__data_in_valid  = 4'b0110;
        bus.i__clear_all      = 1'b1;
        #1;
        check("clr_ready", 64'(bus.o__data_in_ready), 64'd0);
        tick();
        check("clr_out_valid", 64'(bus.o__data_out_valid), 64'd0);
        bus.i__clear_all = 1'b0;
        #1;
        check("clr_next_ready", 64'(bus.o__data_in_ready), 64'b0010);
        bus.i__data_out_ready = 1'b1;
        tick();
        check_out("clr_next", 64'hA1, 2'd1);

        // Reset in the middle of a stream.
        bus.i__data_in_valid = 4'b1111;
        tick();
        check_out("pre_rst", 64'hA2, 2'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.o__data_in_ready), 64'd0);
        tick();
        check("mid_rst_valid", 64'(bus.o__data_out_valid), 64'd0);
        check("mid_rst_idx", 64'(bus.o__grant_idx), 64'd0);
        check("mid_rst_ready2", 64'(bus.o__data_in_ready), 64'd0);
        tick();
        reset = 1'b0;
        exp_d = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA0};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int s = 0; s < 5; s++) begin
            tick();
            check_out("rr2", exp_d[s], exp_i[s]);
        end

        // Idle drain: free slot with no requests empties the register.
        bus.i__data_in_valid = 4'b0000;
        tick();
        check("idle_valid", 64'(bus.o__data_out_valid), 64'd0);
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/port_output_arbiter.md
PORT_OUTPUT_ARBITER -- requirements
Module: port_output_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each data word.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, number of competing fifo_base output interfaces (2..8).
REQ-003 SHALL have localparam IDX_WIDTH = $clog2(NUM_INPUTS).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 i__data_in_valid  input  NUM_INPUTS  per-input valid, driven from upstream fifo_base o__data_out_valid.
REQ-007 i__data_in  input  NUM_INPUTS x DATA_WIDTH (unpacked array)  per-input data.
REQ-008 o__data_in_ready  output  NUM_INPUTS  per-input ready, fed back as the FIFO pop (i__data_out_ready).
REQ-009 o__data_out_valid  output  1  output register holds a word.
REQ-010 o__data_out  output  DATA_WIDTH  output register contents.
REQ-011 i__data_out_ready  input  1  downstream accepts o__data_out this cycle.
REQ-012 o__grant_idx  output  IDX_WIDTH  source index of the word in the output register.
REQ-013 i__clear_all  input  1  flush: drop the output register word and reset the priority pointer.

Function
REQ-014 Output transfer SHALL occur when o__data_out_valid && i__data_out_ready; input transfer on input k SHALL occur when i__data_in_valid[k] && o__data_in_ready[k].
REQ-015 Output register SHALL be a one-entry pipeline slot; "slot free" = !o__data_out_valid || i__data_out_ready.
REQ-016 Arbitration SHALL be round-robin: search starts at index (r__last_grant + 1) mod NUM_INPUTS and picks the first k with i__data_in_valid[k]=1, wrapping past NUM_INPUTS-1 to 0.
REQ-017 o__data_in_ready[k] SHALL be 1 only for the selected k, and only when slot free, !i__clear_all and !reset; at most one bit SHALL be set in any cycle.
REQ-018 o__data_in_ready SHALL be combinational from the current-cycle valids and registered state; valid-to-ready paths are permitted; ready-to-valid paths are not.
REQ-019 On an input transfer, the output register SHALL load i__data_in[k], o__grant_idx SHALL load k, and o__data_out_valid SHALL be 1 the next cycle (latency 1 cycle, input to output).
REQ-020 r__last_grant SHALL update to k only on an input transfer and SHALL hold otherwise.
REQ-021 If the slot is free and no input is valid, o__data_out_valid SHALL go to 0 next cycle.
REQ-022 Simultaneous output transfer and input transfer SHALL sustain 1 word/cycle with no bubble.
REQ-023 If o__data_out_valid=1 and i__data_out_ready=0, o__data_out and o__grant_idx SHALL hold stable, and all o__data_in_ready SHALL be 0.
REQ-024 A continuously valid input SHALL be granted within NUM_INPUTS output transfers (starvation freedom).
REQ-025 i__clear_all=1 SHALL clear o__data_out_valid and set r__last_grant = NUM_INPUTS-1 next cycle, with no input transfer that cycle; the dropped word SHALL not be reported to downstream.
REQ-026 The output data register SHALL be loaded only on an input transfer; the data path need not be reset.

Reset
REQ-027 During reset: o__data_out_valid=0, o__data_in_ready=0, o__grant_idx=0, r__last_grant=NUM_INPUTS-1 (first grant after reset goes to the lowest valid index).
REQ-028 Reset mid-operation SHALL discard the word in the output register without a transfer; o__data_out is don't-care while o__data_out_valid=0.

Verification
REQ-029 Reset, then valid=4'b1111, data k=0xA0+k, out_ready=1 -> outputs 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles; grant_idx 0,1,2,3,0.
REQ-030 valid=4'b0101 held, out_ready=1 -> grants alternate 0,2,0,2; ready[1] and ready[3] never 1.
REQ-031 Word 0x55 in the output register, out_ready=0 for 5 cycles, inputs valid -> data stable at 0x55, all ready=0; out_ready=1 -> 0x55 accepted, next word appears the following cycle.
REQ-032 Last grant = 3 (wrap): valid=4'b1001 -> next grant 0, then 3.
REQ-033 Register full, then i__clear_all=1 for 1 cycle -> out_valid=0 next cycle, no ready asserted that cycle, next grant = lowest valid index.
REQ-034 Reset asserted mid-stream with out_valid=1 -> out_valid=0 and ready=0 on the following cycle; after release, ordering matches REQ-029.
REQ-035 Bench SHALL check every cycle: one-hot-or-zero ready, no data loss or duplication versus a reference queue, output stable under backpressure.
